// File: rtl/imem_loader_pkg.sv
// Shared definitions for the boot-time instruction loader: FSM states,
// stream framing constants and the header legality check.
package imem_loader_pkg;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_HDR0 = 3'd1,
        ST_HDR1 = 3'd2,
        ST_DATA = 3'd3,
        ST_HOLD = 3'd4,
        ST_RUN  = 3'd5,
        ST_ERR  = 3'd6
    } state_t;

    localparam int HDR_BYTES      = 2;
    localparam int BYTES_PER_WORD = 4;

    // A header is usable only if it names at least one word and fits the memory.
    function automatic logic count_legal(input logic [15:0] count, input int depth);
        return (count != 16'd0) && ({16'd0, count} <= $unsigned(depth));
    endfunction

endpackage

// File: rtl/imem_loader_byte_word_assembler.sv
// Little-endian byte-to-word assembler: collects three bytes in a shift
// register and presents the full word alongside the fourth byte.
module byte_word_assembler
    import imem_loader_pkg::*;
(
    input  logic        CLK,
    input  logic        resetl,
    input  logic        clear,
    input  logic        byte_en,
    input  logic [7:0]  byte_data,
    output logic [31:0] word,
    output logic        word_valid
);

    localparam int LANES = BYTES_PER_WORD - 1;

    logic [7:0] lane_reg [LANES];
    logic [1:0] byte_cnt_reg;
    logic       last_byte;

    assign last_byte  = (byte_cnt_reg == 2'(BYTES_PER_WORD - 1));
    assign word_valid = byte_en && last_byte;

    always_ff @(posedge CLK) begin
        if (!resetl || clear) begin
            byte_cnt_reg <= 2'd0;
        end else if (byte_en) begin
            byte_cnt_reg <= byte_cnt_reg + 2'd1;
        end
    end

    // Newest byte enters the top lane, so after three shifts lane 0 holds byte 0.
    genvar gi;
    generate
        for (gi = 0; gi < LANES; gi++) begin : g_lane
            if (gi == LANES - 1) begin : g_top
                always_ff @(posedge CLK) begin
                    if (!resetl || clear) begin
                        lane_reg[gi] <= 8'd0;
                    end else if (byte_en) begin
                        lane_reg[gi] <= byte_data;
                    end
                end
            end else begin : g_mid
                always_ff @(posedge CLK) begin
                    if (!resetl || clear) begin
                        lane_reg[gi] <= 8'd0;
                    end else if (byte_en) begin
                        lane_reg[gi] <= lane_reg[gi+1];
                    end
                end
            end
            assign word[8*gi +: 8] = lane_reg[gi];
        end
    endgenerate

    assign word[31:24] = byte_data;

endmodule

// File: rtl/imem_loader.sv
// Boot loader: parses a counted little-endian byte stream into instruction
// memory writes, then hands startpc to the core and releases its reset.
module imem_loader
    import imem_loader_pkg::*;
#(
    parameter int DEPTH_WORDS = 64,
    parameter int ADDR_W      = 6,
    parameter int HOLD_CYCLES = 2
) (
    input  logic              CLK,
    input  logic              resetl,
    input  logic              load_start,
    input  logic [63:0]       start_pc_in,
    input  logic              byte_valid,
    input  logic [7:0]        byte_data,
    output logic              byte_ready,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_waddr,
    output logic [31:0]       imem_wdata,
    output logic              cpu_resetl,
    output logic [63:0]       startpc,
    output logic              busy,
    output logic              err
);

    state_t             state_reg, state_next;
    logic [15:0]        count_reg;
    logic [ADDR_W-1:0]  addr_reg;
    logic [3:0]         hold_cnt_reg;
    logic [63:0]        start_pc_reg;
    logic               imem_we_reg;
    logic [ADDR_W-1:0]  imem_waddr_reg;
    logic [31:0]        imem_wdata_reg;

    logic               accept;
    logic               start_accept;
    logic               data_en;
    logic [31:0]        asm_word;
    logic               word_valid;

    assign accept       = byte_valid && byte_ready;
    assign start_accept = load_start &&
                          ((state_reg == ST_IDLE) || (state_reg == ST_RUN) || (state_reg == ST_ERR));
    assign data_en      = accept && (state_reg == ST_DATA);

    byte_word_assembler u_asm (
        .CLK        (CLK),
        .resetl     (resetl),
        .clear      (start_accept),
        .byte_en    (data_en),
        .byte_data  (byte_data),
        .word       (asm_word),
        .word_valid (word_valid)
    );

    always_ff @(posedge CLK) begin
        if (!resetl) begin
            state_reg <= ST_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE, ST_RUN, ST_ERR: begin
                if (load_start) state_next = ST_HDR0;
            end
            ST_HDR0: begin
                if (accept) state_next = ST_HDR1;
            end
            ST_HDR1: begin
                if (accept) begin
                    state_next = count_legal({byte_data, count_reg[7:0]}, DEPTH_WORDS)
                                 ? ST_DATA : ST_ERR;
                end
            end
            ST_DATA: begin
                if (word_valid && (count_reg == 16'd1)) state_next = ST_HOLD;
            end
            // The write cycle plus HOLD_CYCLES quiet cycles precede release.
            ST_HOLD: begin
                if (hold_cnt_reg == 4'(HOLD_CYCLES)) state_next = ST_RUN;
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_comb begin
        byte_ready = 1'b0;
        busy       = 1'b0;
        err        = 1'b0;
        cpu_resetl = 1'b0;
        case (state_reg)
            ST_HDR0, ST_HDR1, ST_DATA: begin
                byte_ready = 1'b1;
                busy       = 1'b1;
            end
            ST_HOLD: busy       = 1'b1;
            ST_RUN:  cpu_resetl = 1'b1;
            ST_ERR:  err        = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (!resetl) begin
            count_reg      <= 16'd0;
            addr_reg       <= '0;
            hold_cnt_reg   <= 4'd0;
            start_pc_reg   <= 64'd0;
            imem_we_reg    <= 1'b0;
            imem_waddr_reg <= '0;
            imem_wdata_reg <= 32'd0;
        end else begin
            imem_we_reg <= word_valid;
            if (word_valid) begin
                imem_waddr_reg <= addr_reg;
                imem_wdata_reg <= asm_word;
            end

            if (start_accept) begin
                start_pc_reg <= start_pc_in;
                addr_reg     <= '0;
                count_reg    <= 16'd0;
            end else if (accept && (state_reg == ST_HDR0)) begin
                count_reg[7:0] <= byte_data;
            end else if (accept && (state_reg == ST_HDR1)) begin
                count_reg[15:8] <= byte_data;
            end else if (word_valid) begin
                addr_reg  <= addr_reg + 1'b1;
                count_reg <= count_reg - 16'd1;
            end

            if (state_reg == ST_HOLD) begin
                hold_cnt_reg <= hold_cnt_reg + 4'd1;
            end else begin
                hold_cnt_reg <= 4'd0;
            end
        end
    end

    assign imem_we    = imem_we_reg;
    assign imem_waddr = imem_waddr_reg;
    assign imem_wdata = imem_wdata_reg;
    assign startpc    = start_pc_reg;

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader: drives counted byte streams and checks
// writes, handshake, error handling and the processor release timing.
module tb_imem_loader;
    import imem_loader_pkg::*;

    logic        CLK = 1'b0;
    logic        resetl;
    logic        load_start;
    logic [63:0] start_pc_in;
    logic        byte_valid;
    logic [7:0]  byte_data;
    logic        byte_ready;
    logic        imem_we;
    logic [5:0]  imem_waddr;
    logic [31:0] imem_wdata;
    logic        cpu_resetl;
    logic [63:0] startpc;
    logic        busy;
    logic        err;

    int errors = 0;
    int checks = 0;
    int cyc    = 0;
    int wr_cnt = 0;
    int          wr_addr [32];
    logic [31:0] wr_data [32];
    int          wr_cyc  [32];

    imem_loader #(.DEPTH_WORDS(64), .ADDR_W(6), .HOLD_CYCLES(2)) dut (
        .CLK         (CLK),
        .resetl      (resetl),
        .load_start  (load_start),
        .start_pc_in (start_pc_in),
        .byte_valid  (byte_valid),
        .byte_data   (byte_data),
        .byte_ready  (byte_ready),
        .imem_we     (imem_we),
        .imem_waddr  (imem_waddr),
        .imem_wdata  (imem_wdata),
        .cpu_resetl  (cpu_resetl),
        .startpc     (startpc),
        .busy        (busy),
        .err         (err)
    );

    always #5 CLK = ~CLK;

    // Write recorder, sampled mid-cycle.
    always @(negedge CLK) begin
        cyc <= cyc + 1;
        if (imem_we && wr_cnt < 32) begin
            wr_addr[wr_cnt] <= int'(imem_waddr);
            wr_data[wr_cnt] <= imem_wdata;
            wr_cyc[wr_cnt]  <= cyc;
            wr_cnt          <= wr_cnt + 1;
        end
    end

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic pulse_start(input logic [63:0] pc);
        start_pc_in = pc;
        load_start  = 1'b1;
        step();
        load_start  = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b);
        int   n;
        logic rdy;
        n          = 0;
        byte_valid = 1'b1;
        byte_data  = b;
        do begin
            rdy = byte_ready;
            step();
            n++;
        end while (!rdy && n < 50);
        byte_valid = 1'b0;
        checks++;
        if (rdy !== 1'b1) begin
            errors++;
            $display("FAIL send_byte: byte %h not accepted, byte_ready=%b required 1", b, rdy);
        end
    endtask

    task automatic send_word(input logic [31:0] w);
        for (int i = 0; i < BYTES_PER_WORD; i++) send_byte(w[8*i +: 8]);
    endtask

    task automatic send_header(input logic [15:0] count);
        logic [15:0] c;
        c = count;
        for (int i = 0; i < HDR_BYTES; i++) send_byte(c[8*i +: 8]);
    endtask

    task automatic wait_run();
        int n;
        n = 0;
        while (cpu_resetl !== 1'b1 && n < 20) begin
            step();
            n++;
        end
        checks++;
        if (cpu_resetl !== 1'b1) begin
            errors++;
            $display("FAIL wait_run: cpu_resetl=%b after %0d cycles, required 1", cpu_resetl, n);
        end
    endtask

    task automatic test_reset();
        resetl = 1'b0; load_start = 1'b0; start_pc_in = 64'h0;
        byte_valid = 1'b0; byte_data = 8'h00;
        repeat (3) step();
        checks += 8;
        if (cpu_resetl !== 1'b0) begin errors++; $display("FAIL reset_cpu_resetl: got %b required 0", cpu_resetl); end
        if (startpc !== 64'h0)   begin errors++; $display("FAIL reset_startpc: got %h required 0", startpc); end
        if (byte_ready !== 1'b0) begin errors++; $display("FAIL reset_byte_ready: got %b required 0", byte_ready); end
        if (imem_we !== 1'b0)    begin errors++; $display("FAIL reset_imem_we: got %b required 0", imem_we); end
        if (imem_waddr !== 6'd0) begin errors++; $display("FAIL reset_waddr: got %h required 0", imem_waddr); end
        if (imem_wdata !== 32'h0) begin errors++; $display("FAIL reset_wdata: got %h required 0", imem_wdata); end
        if (busy !== 1'b0)       begin errors++; $display("FAIL reset_busy: got %b required 0", busy); end
        if (err !== 1'b0)        begin errors++; $display("FAIL reset_err: got %b required 0", err); end
        resetl = 1'b1;
        step();
        $display("test_reset: done");
    endtask

    task automatic test_basic_load();
        int   base;
        logic exp_rl;
        base = wr_cnt;
        pulse_start(64'h0);
        checks += 2;
        if (busy !== 1'b1)       begin errors++; $display("FAIL basic_busy: got %b required 1", busy); end
        if (byte_ready !== 1'b1) begin errors++; $display("FAIL basic_ready: got %b required 1", byte_ready); end
        send_header(16'd2);
        send_word(32'h12345678);
        send_word(32'h9ABCDEF0);
        // Now one tick past the edge that took the final byte.
        for (int k = 1; k <= 3; k++) begin
            step();
            exp_rl = (k == 3);
            checks++;
            if (cpu_resetl !== exp_rl) begin
                errors++;
                $display("FAIL basic_release_t%0d: cpu_resetl=%b required %b", k, cpu_resetl, exp_rl);
            end
        end
        checks += 7;
        if (wr_cnt !== base + 2) begin errors++; $display("FAIL basic_wr_count: got %0d required %0d", wr_cnt - base, 2); end
        if (wr_addr[base] !== 0) begin errors++; $display("FAIL basic_addr0: got %0d required 0", wr_addr[base]); end
        if (wr_data[base] !== 32'h12345678) begin errors++; $display("FAIL basic_data0: got %h required 12345678", wr_data[base]); end
        if (wr_addr[base+1] !== 1) begin errors++; $display("FAIL basic_addr1: got %0d required 1", wr_addr[base+1]); end
        if (wr_data[base+1] !== 32'h9ABCDEF0) begin errors++; $display("FAIL basic_data1: got %h required 9abcdef0", wr_data[base+1]); end
        if (wr_cyc[base+1] - wr_cyc[base] !== 4) begin errors++; $display("FAIL basic_write_spacing: got %0d required 4", wr_cyc[base+1] - wr_cyc[base]); end
        if (startpc !== 64'h0) begin errors++; $display("FAIL basic_startpc: got %h required 0", startpc); end
        $display("test_basic_load: done, writes=%0d", wr_cnt - base);
    endtask

    task automatic test_zero_count();
        int base;
        base = wr_cnt;
        pulse_start(64'h0);
        send_header(16'd0);
        repeat (3) step();
        checks += 5;
        if (err !== 1'b1)        begin errors++; $display("FAIL zero_err: got %b required 1", err); end
        if (cpu_resetl !== 1'b0) begin errors++; $display("FAIL zero_cpu_resetl: got %b required 0", cpu_resetl); end
        if (byte_ready !== 1'b0) begin errors++; $display("FAIL zero_ready: got %b required 0", byte_ready); end
        if (busy !== 1'b0)       begin errors++; $display("FAIL zero_busy: got %b required 0", busy); end
        if (wr_cnt !== base)     begin errors++; $display("FAIL zero_no_write: got %0d writes required 0", wr_cnt - base); end
        pulse_start(64'h8);
        checks += 2;
        if (err !== 1'b0)  begin errors++; $display("FAIL zero_err_clear: got %b required 0", err); end
        if (busy !== 1'b1) begin errors++; $display("FAIL zero_restart_busy: got %b required 1", busy); end
        $display("test_zero_count: done");
    endtask

    task automatic test_over_count();
        int base;
        base = wr_cnt;
        send_header(16'h0041);
        checks++;
        if (err !== 1'b1) begin errors++; $display("FAIL over_err: got %b required 1", err); end
        byte_valid = 1'b1;
        byte_data  = 8'hAA;
        for (int k = 0; k < 3; k++) begin
            checks++;
            if (byte_ready !== 1'b0) begin
                errors++;
                $display("FAIL over_ready_c%0d: got %b required 0", k, byte_ready);
            end
            step();
        end
        byte_valid = 1'b0;
        checks += 2;
        if (err !== 1'b1)    begin errors++; $display("FAIL over_err_held: got %b required 1", err); end
        if (wr_cnt !== base) begin errors++; $display("FAIL over_no_write: got %0d writes required 0", wr_cnt - base); end
        $display("test_over_count: done");
    endtask

    task automatic test_gapped_stream();
        int          base;
        logic [31:0] w;
        base = wr_cnt;
        w    = 32'hCAFEBABE;
        pulse_start(64'h10);
        send_header(16'd1);
        for (int i = 0; i < 4; i++) begin
            byte_valid = 1'b1;
            byte_data  = w[8*i +: 8];
            checks++;
            if (byte_ready !== 1'b1) begin errors++; $display("FAIL gap_ready_b%0d: got %b required 1", i, byte_ready); end
            step();
            byte_valid = 1'b0;
            if (i < 3) begin
                checks++;
                if (byte_ready !== 1'b1) begin errors++; $display("FAIL gap_ready_idle%0d: got %b required 1", i, byte_ready); end
                // A start request mid-load must be ignored.
                start_pc_in = 64'h99;
                load_start  = 1'b1;
                step();
                load_start  = 1'b0;
            end
        end
        wait_run();
        checks += 4;
        if (wr_cnt !== base + 1) begin errors++; $display("FAIL gap_wr_count: got %0d required 1", wr_cnt - base); end
        if (wr_addr[base] !== 0) begin errors++; $display("FAIL gap_addr: got %0d required 0", wr_addr[base]); end
        if (wr_data[base] !== 32'hCAFEBABE) begin errors++; $display("FAIL gap_data: got %h required cafebabe", wr_data[base]); end
        if (startpc !== 64'h10) begin errors++; $display("FAIL gap_startpc: got %h required 10", startpc); end
        $display("test_gapped_stream: done");
    endtask

    task automatic test_abort();
        int base;
        base = wr_cnt;
        pulse_start(64'h20);
        send_header(16'd1);
        send_byte(8'h11);
        send_byte(8'h22);
        resetl = 1'b0;
        step();
        checks += 9;
        if (cpu_resetl !== 1'b0) begin errors++; $display("FAIL abort_cpu_resetl: got %b required 0", cpu_resetl); end
        if (startpc !== 64'h0)   begin errors++; $display("FAIL abort_startpc: got %h required 0", startpc); end
        if (byte_ready !== 1'b0) begin errors++; $display("FAIL abort_ready: got %b required 0", byte_ready); end
        if (imem_we !== 1'b0)    begin errors++; $display("FAIL abort_we: got %b required 0", imem_we); end
        if (imem_waddr !== 6'd0) begin errors++; $display("FAIL abort_waddr: got %h required 0", imem_waddr); end
        if (imem_wdata !== 32'h0) begin errors++; $display("FAIL abort_wdata: got %h required 0", imem_wdata); end
        if (busy !== 1'b0)       begin errors++; $display("FAIL abort_busy: got %b required 0", busy); end
        if (err !== 1'b0)        begin errors++; $display("FAIL abort_err: got %b required 0", err); end
        if (wr_cnt !== base)     begin errors++; $display("FAIL abort_no_write: got %0d writes required 0", wr_cnt - base); end
        resetl = 1'b1;
        step();
        pulse_start(64'h0);
        send_header(16'd1);
        send_word(32'h0000000F);
        wait_run();
        checks += 3;
        if (wr_cnt !== base + 1) begin errors++; $display("FAIL abort_reload_count: got %0d required 1", wr_cnt - base); end
        if (wr_addr[base] !== 0) begin errors++; $display("FAIL abort_reload_addr: got %0d required 0", wr_addr[base]); end
        if (wr_data[base] !== 32'h0000000F) begin errors++; $display("FAIL abort_reload_data: got %h required 0000000f", wr_data[base]); end
        $display("test_abort: done");
    endtask

    task automatic test_reload();
        int base;
        base = wr_cnt;
        checks++;
        if (cpu_resetl !== 1'b1) begin errors++; $display("FAIL reload_pre_run: got %b required 1", cpu_resetl); end
        pulse_start(64'h30);
        checks += 3;
        if (cpu_resetl !== 1'b0) begin errors++; $display("FAIL reload_drop: got %b required 0", cpu_resetl); end
        if (startpc !== 64'h30)  begin errors++; $display("FAIL reload_pc_latch: got %h required 30", startpc); end
        if (busy !== 1'b1)       begin errors++; $display("FAIL reload_busy: got %b required 1", busy); end
        send_header(16'd1);
        send_word(32'h00000013);
        wait_run();
        checks += 4;
        if (startpc !== 64'h30)  begin errors++; $display("FAIL reload_startpc: got %h required 30", startpc); end
        if (wr_cnt !== base + 1) begin errors++; $display("FAIL reload_wr_count: got %0d required 1", wr_cnt - base); end
        if (wr_addr[base] !== 0) begin errors++; $display("FAIL reload_addr: got %0d required 0", wr_addr[base]); end
        if (wr_data[base] !== 32'h00000013) begin errors++; $display("FAIL reload_data: got %h required 00000013", wr_data[base]); end
        $display("test_reload: done");
    endtask

    initial begin
        test_reset();
        test_basic_load();
        test_zero_count();
        test_over_count();
        test_gapped_stream();
        test_abort();
        test_reload();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/imem_loader.md
# imem_loader

Boot-time instruction loader that sits directly upstream of `singlecycle`. It receives a byte stream over a valid/ready interface and assembles little-endian 32-bit instructions. It writes them into the processor's instruction memory write port, holding the processor in reset throughout. When loading completes it drives `startpc` and releases the processor's `resetl`, replacing the bench-driven reset/startpc sequence.

## Interface
Parameters:
- `DEPTH_WORDS`, 64, instruction memory depth in 32-bit words (max loadable count).
- `ADDR_W`, 6, width of the word address; must satisfy 2^ADDR_W >= DEPTH_WORDS.
- `HOLD_CYCLES`, 2, cycles `cpu_resetl` stays low after the last write (1..15).

Ports:
- `CLK`  in  1  system clock; all state changes on posedge.
- `resetl`  in  1  reset, synchronous, active-low.
- `load_start`  in  1  single-cycle request to begin a load.
- `start_pc_in`  in  64  PC to hand to the processor, latched when `load_start` is accepted.
- `byte_valid`  in  1  a byte is present on `byte_data`.
- `byte_data`  in  8  stream byte.
- `byte_ready`  out  1  loader accepts a byte this cycle.
- `imem_we`  out  1  instruction memory write strobe.
- `imem_waddr`  out  ADDR_W  word address of the write.
- `imem_wdata`  out  32  instruction word.
- `cpu_resetl`  out  1  drives `singlecycle.resetl`.
- `startpc`  out  64  drives `singlecycle.startpc`.
- `busy`  out  1  load in progress (HDR0..HOLD).
- `err`  out  1  illegal word count received.

## Operation
- Stream format: byte0 = count[7:0], byte1 = count[15:8], then count×4 instruction bytes, each word LSB first.
- FSM states: IDLE, HDR0, HDR1, DATA, HOLD, RUN, ERR.
- IDLE: on `load_start` → HDR0, latch `start_pc_in`, clear the word address to 0.
- HDR0/HDR1: capture count bytes. After HDR1, if count == 0 or count > DEPTH_WORDS → ERR, else → DATA.
- DATA: shift in bytes, with a byte counter 0..3. On the 4th byte, write the assembled word at the current address, increment the address, and decrement the remaining count. After the last word → HOLD.
- HOLD: count HOLD_CYCLES cycles, then → RUN.
- RUN: `cpu_resetl` = 1. `load_start` → HDR0 (reload), and `cpu_resetl` drops to 0 in the next cycle.
- ERR: `err` = 1 and `cpu_resetl` = 0. Only `load_start` leaves ERR (→ HDR0, `err` cleared).
- `load_start` is ignored in HDR0, HDR1, DATA and HOLD.
- `byte_ready` = 1 only in HDR0, HDR1 and DATA. Bytes offered in other states are not consumed.
- `startpc` holds its latched value continuously, including in RUN.

## Timing
- A byte is accepted on the posedge where `byte_valid && byte_ready`. Gaps in `byte_valid` are legal; no timeout.
- `imem_we` is a registered one-cycle pulse in the cycle after the 4th byte of a word is accepted, with `imem_waddr`/`imem_wdata` valid in the same cycle.
- Back-to-back words at full rate: one write every 4 cycles.
- The last write occurs in the first HOLD cycle. `cpu_resetl` rises exactly HOLD_CYCLES+1 cycles after the final byte is accepted.
- Reset values: `cpu_resetl` 0, `startpc` 0, `byte_ready` 0, `imem_we` 0, `imem_waddr` 0, `imem_wdata` 0, `busy` 0, `err` 0, state IDLE.
- `resetl` low mid-load aborts the load: the next cycle has all outputs at reset values, and partial words are discarded.
- The address never wraps, because count is bounded by DEPTH_WORDS.

## Structure
- A shared package holds the FSM state enum, the stream header length (2) and the bytes-per-word constant (4), for reuse by the bench's stream driver.
- One sub-module, `byte_word_assembler`: a 4-byte little-endian shift register with byte counter and a `word_valid` pulse.
- The FSM, address/count counters and hold counter stay in `imem_loader`.

## Test plan
- Reset then `load_start` with `start_pc_in`=0x0 and stream 02 00 | 78 56 34 12 | F0 DE BC 9A → writes 0x12345678 @0 and 0x9ABCDEF0 @1. `cpu_resetl` rises 3 cycles after the last byte and `startpc`=0.
- Count 00 00 → ERR, `err`=1, `cpu_resetl`=0, no `imem_we`. A subsequent `load_start` clears `err`.
- Count 0x0041 (65 > 64) → ERR, with no bytes consumed after the header.
- Stream with `byte_valid` toggling every other cycle for 1 word → single correct write. `byte_ready` stays high throughout DATA.
- `resetl` low after 2 of 4 data bytes → all outputs at reset values next cycle. A fresh load of 1 word 0xF writes 0x0000000F @0.
- In RUN, `load_start` with `start_pc_in`=0x30 → `cpu_resetl` 0 next cycle. After a 1-word reload, `startpc`=0x30 and `cpu_resetl` returns to 1.
